// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-subset sequencing controller (Moore FSM, Mealy IR/PC load in FETCH).
// Stalls on MemReady in memory states and halts with BusErr when memory hangs.
// Optional build macro MCTRL_PERF_EN adds InstrCount/StallCount performance counters.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       RegB,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       Illegal,
    output logic       BusErr
`ifdef MCTRL_PERF_EN
    ,
    output logic [31:0] InstrCount,
    output logic [31:0] StallCount
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IEXEC    = 4'd10,
        S_IWB      = 4'd11,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             illegal_q, bus_err_q;
    logic             set_illegal;
    logic             mem_state, timeout, wait_inc;
    logic             r_valid, r_regb;
    logic [3:0]       r_aluop;

    // R-type function decode; IR is stable outside FETCH so EXEC and RWB agree.
    always_comb begin
        r_valid = 1'b1;
        r_regb  = 1'b0;
        r_aluop = ALU_ADD;
        case (Func)
            6'b100000: r_aluop = ALU_ADD;
            6'b100010: r_aluop = ALU_SUB;
            6'b100100: r_aluop = ALU_AND;
            6'b100101: r_aluop = ALU_OR;
            6'b101010: r_aluop = ALU_SLT;
            6'b000000: begin
                r_aluop = ALU_SLL;
                r_regb  = 1'b1;
            end
            default:   r_valid = 1'b0;
        endcase
    end

    // Memory-wait bookkeeping: a stall that reaches the limit becomes a timeout instead of a count.
    always_comb begin
        mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
        timeout   = (MEM_TIMEOUT != 0) && mem_state && !MemReady &&
                    (wait_cnt == CNT_W'(MEM_TIMEOUT));
        wait_inc  = mem_state && !MemReady && !timeout;
    end

    // Next-state and per-state outputs; everything is zero while Reset is high.
    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        RegB        = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_ADD;
        PCSource    = 2'b00;
        State       = 4'd0;
        Illegal     = 1'b0;
        BusErr      = 1'b0;
        if (!Reset) begin
            State   = state;
            Illegal = illegal_q;
            BusErr  = bus_err_q;
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    if (timeout) begin
                        next_state = S_HALT;
                    end else if (MemReady) begin
                        IRWrite    = 1'b1;
                        PCWrite    = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (Op)
                        OP_R: begin
                            next_state  = r_valid ? S_EXEC : S_HALT;
                            set_illegal = !r_valid;
                        end
                        OP_LW, OP_SW:   next_state = S_MEMADDR;
                        OP_BEQ, OP_BNE: next_state = S_BRANCH;
                        OP_J:           next_state = S_JUMP;
                        OP_ADDI:        next_state = S_IEXEC;
                        default: begin
                            next_state  = S_HALT;
                            set_illegal = 1'b1;
                        end
                    endcase
                end
                S_MEMADDR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    next_state = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    if (timeout)       next_state = S_HALT;
                    else if (MemReady) next_state = S_MEMWB;
                end
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEMWRITE: begin
                    IorD = 1'b1;
                    if (timeout) begin
                        next_state = S_HALT;
                    end else begin
                        MemWrite = 1'b1;
                        if (MemReady) next_state = S_FETCH;
                    end
                end
                S_EXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUOp      = r_aluop;
                    RegB       = r_regb;
                    next_state = S_RWB;
                end
                S_RWB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    ALUOp      = r_aluop;
                    RegB       = r_regb;
                    next_state = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUOp      = ALU_SUB;
                    PCSource   = 2'b01;
                    PCWrite    = (Op == OP_BNE) ? !Zero : Zero;
                    next_state = S_FETCH;
                end
                S_JUMP: begin
                    PCSource   = 2'b10;
                    PCWrite    = 1'b1;
                    next_state = S_FETCH;
                end
                S_IEXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    next_state = S_IWB;
                end
                S_IWB: begin
                    RegWrite   = 1'b1;
                    next_state = S_FETCH;
                end
                S_HALT:  next_state = S_HALT;
                default: next_state = S_HALT;
            endcase
        end
    end

    // State register, wait counter and sticky error flags.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state) wait_cnt <= '0;
            else if (wait_inc)       wait_cnt <= wait_cnt + 1'b1;
            if (set_illegal) illegal_q <= 1'b1;
            if (timeout)     bus_err_q <= 1'b1;
        end
    end

`ifdef MCTRL_PERF_EN
    logic instr_done;
    assign instr_done = (next_state == S_FETCH) &&
                        ((state == S_MEMWB) || (state == S_MEMWRITE) || (state == S_RWB) ||
                         (state == S_BRANCH) || (state == S_JUMP) || (state == S_IWB));

    // Retired-instruction and memory-stall counters, free-running with wrap.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            InstrCount <= '0;
            StallCount <= '0;
        end else begin
            if (instr_done) InstrCount <= InstrCount + 32'd1;
            if (wait_inc)   StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style sequencing FSM for the multi-cycle version of the 32-bit MIPS-subset datapath. It replaces the single-cycle controller. It drives PC, instruction register, register-file, ALU-mux and memory enables state by state from the opcode and function fields of the latched instruction. A MemReady handshake with the shared instruction/data memory lets fetch and load/store stall. A timeout counter forces a halt on a hung memory.

Parameters:
MEM_TIMEOUT, 15, max consecutive MemReady=0 cycles tolerated in a memory state; 0 disables the timeout.
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
Clock in 1 system clock, rising edge
Reset in 1 synchronous, active-high
Op in 6 instruction[31:26] from IR
Func in 6 instruction[5:0] from IR
Zero in 1 ALU zero flag
MemReady in 1 memory completes current access this cycle
PCWrite out 1 PC load enable
IorD out 1 memory address select: 0=PC, 1=ALUOut
IRWrite out 1 IR load enable
MemRead out 1 memory read request
MemWrite out 1 memory write request
MemtoReg out 1 write-back select: 0=ALUOut, 1=MDR
RegDst out 1 write register select: 0=rt, 1=rd
RegWrite out 1 register file write enable
RegB out 1 ALU B uses shamt (instr[10:6])
ALUSrcA out 1 ALU A select: 0=PC, 1=regA
ALUSrcB out 2 ALU B select: 00=regB, 01=const 4, 10=sign-ext, 11=sign-ext<<2
ALUOp out 4 ALU control code
PCSource out 2 PC input select: 00=ALU result, 01=ALUOut, 10=jump target
State out 4 current state encoding, for debug
Illegal out 1 sticky: undefined opcode/func decoded
BusErr out 1 sticky: memory timeout

Behaviour:
- ALU codes: add=0000, sub=0001, and=0010, or=0011, slt=0100, sll=1000.
- R-type func map: 100000→add, 100010→sub, 100100→and, 100101→or, 101010→slt, 000000→sll (RegB=1). Any other func is illegal.
- Supported opcodes: 000000 R, 100011 lw, 101011 sw, 000100 beq, 000101 bne, 001000 addi, 000010 j. Any other opcode is illegal.
- Outputs are not listed per state below; every unlisted output is 0 in that state.
- States and encodings:
  - FETCH=0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add. IRWrite=PCWrite=MemReady (same cycle, Mealy), PCSource=00. Go to DECODE when MemReady=1, else stay.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut).
    - R→EXEC (or HALT if func illegal); lw/sw→MEMADDR; beq/bne→BRANCH; j→JUMP; addi→IEXEC; otherwise HALT.
  - MEMADDR=2: ALUSrcA=1, ALUSrcB=10, add. Go to MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD=3: IorD=1, MemRead=1. Wait for MemReady, then MEMWB.
  - MEMWB=4: RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
  - MEMWRITE=5: IorD=1, MemWrite=1. Wait for MemReady, then FETCH.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUOp from func, RegB=(func==000000). Go to RWB.
  - RWB=7: RegDst=1, RegWrite=1, ALUOp/RegB held from EXEC. Go to FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01. PCWrite = Zero for beq, ~Zero for bne. Go to FETCH.
  - JUMP=9: PCSource=10, PCWrite=1. Go to FETCH.
  - IEXEC=10: ALUSrcA=1, ALUSrcB=10, add. Go to IWB.
  - IWB=11: RegDst=0, MemtoReg=0, RegWrite=1, ALUOp=add. Go to FETCH.
  - HALT=15: all enables 0. Stays in HALT until Reset.
- Illegal sets to 1 on the DECODE→HALT transition.
- Wait counter:
  - Increments each cycle in FETCH/MEMREAD/MEMWRITE while MemReady=0.
  - Clears on any state change.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with MemReady still 0: next state is HALT, BusErr=1, and no write/IR/PC enable is asserted in that cycle.
  - MemReady=1 on the timeout cycle wins: the access completes normally.
- Reset:
  - While Reset=1, all outputs are forced to 0.
  - On the clock edge with Reset=1: state←FETCH, counter←0, Illegal←0, BusErr←0.
  - Reset asserted mid-instruction (including mid-stall) aborts the instruction with no further register or memory writes.
- Latency: R/addi 4 cycles, lw 5, sw 4, beq/bne/j 3, each plus memory stall cycles.

Optional Feature:
MCTRL_PERF_EN: adds outputs InstrCount[31:0] and StallCount[31:0].
- Both counters reset to 0 on Reset.
- InstrCount increments on each transition into FETCH from a completing state (MEMWB, MEMWRITE, RWB, BRANCH, JUMP, IWB).
- StallCount increments each cycle the wait counter increments.
- Both counters wrap at 2^32.
- Without the macro, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released with MemReady=1 and Op=000000/Func=100000 → states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; ALUOp=0000 in state 6.
- lw (Op=100011), MemReady low 3 cycles in MEMREAD → state 3 held 4 cycles, then 4 with MemtoReg=1, RegWrite=1; StallCount=3 if PERF enabled.
- beq with Zero=1 → PCWrite=1, PCSource=01 in state 8; repeat with Zero=0 → PCWrite=0. bne with Zero=0 → PCWrite=1.
- Op=111111 → state 1 then 15; Illegal=1; all enables 0 for 10 further cycles; Reset returns state to 0 and clears Illegal.
- MEM_TIMEOUT=15, MemReady held 0 in FETCH → HALT after 15 stall cycles, BusErr=1, IRWrite never asserted.
- Reset asserted in state 5 with MemReady=0 → next cycle state 0; MemWrite=0 during the reset cycle.
